// File: rtl/nbit_logic_sweep_unit.sv
// nbit_logic_sweep_unit: registered WIDTH-bit AND/OR/NAND/XOR unit.
// Modes: a single operation under in_valid, or a self-driven exhaustive sweep over every {a,b}.
// Optional feature macro: LU_CHECKSUM_EN adds an XOR checksum of all results in a sweep.
module nbit_logic_sweep_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               sweep_start,
  output logic               busy,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic [WIDTH-1:0]   out_c,
  output logic [WIDTH-1:0]   out_d,
  output logic [WIDTH-1:0]   out_e,
  output logic [WIDTH-1:0]   out_f,
`ifdef LU_CHECKSUM_EN
  output logic [4*WIDTH-1:0] checksum,
`endif
  output logic               sweep_done
);

  localparam int unsigned CntW = 2 * WIDTH;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, valid_q, done_q;
  logic            valid_d, done_d;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q, e_q, f_q;
  logic [WIDTH-1:0] op_a, op_b;
  logic            load;

  // Next-state decode: picks the operand source and whether results load this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    op_a    = in_a;
    op_b    = in_b;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        // sweep_start takes priority; a coincident single request is dropped
        if (sweep_start) begin
          state_d = StSweep;
          cnt_d   = '0;
        end else if (in_valid) begin
          load = 1'b1;
        end
      end
      StSweep: begin
        // b occupies the low half so it toggles fastest
        op_a  = cnt_q[CntW-1:WIDTH];
        op_b  = cnt_q[WIDTH-1:0];
        load  = 1'b1;
        cnt_d = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
        if (&cnt_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    valid_d = load;
  end

  // Control state: FSM, sweep counter, handshake flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != StIdle);
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Result registers: load on a request or sweep step, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      e_q <= '0;
      f_q <= '0;
    end else if (load) begin
      a_q <= op_a;
      b_q <= op_b;
      c_q <= op_a & op_b;
      d_q <= op_a | op_b;
      e_q <= ~(op_a & op_b);
      f_q <= op_a ^ op_b;
    end
  end

`ifdef LU_CHECKSUM_EN
  logic [4*WIDTH-1:0] checksum_q;

  // Checksum accumulator: cleared on sweep start, folds in every sweep result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if ((state_q == StIdle) && sweep_start) begin
      checksum_q <= '0;
    end else if (state_q == StSweep) begin
      checksum_q <= checksum_q ^ {op_a & op_b, op_a | op_b, ~(op_a & op_b), op_a ^ op_b};
    end
  end

  assign checksum = checksum_q;
`endif

  assign busy       = busy_q;
  assign out_valid  = valid_q;
  assign sweep_done = done_q;
  assign out_a      = a_q;
  assign out_b      = b_q;
  assign out_c      = c_q;
  assign out_d      = d_q;
  assign out_e      = e_q;
  assign out_f      = f_q;

endmodule

// File: tb/tb_nbit_logic_sweep_unit.sv
// Self-checking bench for nbit_logic_sweep_unit (WIDTH=4), randomized against a result model.
module tb_nbit_logic_sweep_unit;

  localparam int unsigned W = 4;
  localparam int unsigned N = 1 << (2 * W);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_a, in_b;
  logic         sweep_start;
  logic         busy, out_valid, sweep_done;
  logic [W-1:0] out_a, out_b, out_c, out_d, out_e, out_f;
`ifdef LU_CHECKSUM_EN
  logic [4*W-1:0] checksum;
`endif

  always #5 clk = ~clk;

  nbit_logic_sweep_unit #(.WIDTH(W)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_a        (in_a),
    .in_b        (in_b),
    .sweep_start (sweep_start),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_c       (out_c),
    .out_d       (out_d),
    .out_e       (out_e),
    .out_f       (out_f),
`ifdef LU_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .sweep_done  (sweep_done)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Model of the registered result set (held between loads).
  logic [W-1:0]   m_a, m_b, m_c, m_d, m_e, m_f;
  logic [4*W-1:0] m_cs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_c = '0; m_d = '0; m_e = '0; m_f = '0;
    m_cs = '0;
  endtask

  task automatic model_load(input int unsigned a, input int unsigned b);
    logic [W-1:0] ta, tb;
    ta = W'(a);
    tb = W'(b);
    m_a = ta;
    m_b = tb;
    m_c = ta & tb;
    m_d = ta | tb;
    m_e = ~(ta & tb);
    m_f = ta ^ tb;
  endtask

  task automatic check_outputs(input string tag, input logic v, input logic bz, input logic dn);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".busy"},  32'(busy),      32'(bz));
    check({tag, ".done"},  32'(sweep_done), 32'(dn));
    check({tag, ".a"}, 32'(out_a), 32'(m_a));
    check({tag, ".b"}, 32'(out_b), 32'(m_b));
    check({tag, ".c"}, 32'(out_c), 32'(m_c));
    check({tag, ".d"}, 32'(out_d), 32'(m_d));
    check({tag, ".e"}, 32'(out_e), 32'(m_e));
    check({tag, ".f"}, 32'(out_f), 32'(m_f));
`ifdef LU_CHECKSUM_EN
    check({tag, ".cs"}, 32'(checksum), 32'(m_cs));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic single_op(input string tag, input int unsigned a, input int unsigned b);
    in_valid    = 1'b1;
    sweep_start = 1'b0;
    in_a        = W'(a);
    in_b        = W'(b);
    step();
    model_load(a, b);
    check_outputs(tag, 1'b1, 1'b0, 1'b0);
  endtask

  // Full sweep; with_valid raises in_valid alongside sweep_start to exercise priority.
  task automatic run_sweep(input string tag, input bit with_valid);
    in_valid    = with_valid;
    in_a        = W'($urandom);
    in_b        = W'($urandom);
    sweep_start = 1'b1;
    step();
    in_valid    = 1'b0;
    sweep_start = 1'b0;
    m_cs        = '0;
    check_outputs({tag, ".start"}, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      // Noise on the request inputs must not disturb the sweep.
      in_valid    = 1'($urandom_range(0, 1));
      sweep_start = 1'($urandom_range(0, 1));
      in_a        = W'($urandom);
      in_b        = W'($urandom);
      step();
      model_load(i / (1 << W), i % (1 << W));
      m_cs = m_cs ^ {m_c, m_d, m_e, m_f};
      check_outputs($sformatf("%s.res%0d", tag, i), 1'b1, 1'b1, 1'b0);
    end
    in_valid    = 1'b0;
    sweep_start = 1'b0;
    step();
    check_outputs({tag, ".done"}, 1'b0, 1'b0, 1'b1);
    step();
    check_outputs({tag, ".after"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    in_a        = 4'h3;
    in_b        = 4'h9;
    sweep_start = 1'b0;
    model_reset();
    step();
    step();
    check_outputs("reset", 1'b0, 1'b0, 1'b0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();
    check_outputs("idle", 1'b0, 1'b0, 1'b0);

    // Directed single op with literal expectations.
    single_op("dirA6", 4'hA, 4'h6);
    check("dirA6.c_lit", 32'(out_c), 32'h2);
    check("dirA6.d_lit", 32'(out_d), 32'hE);
    check("dirA6.e_lit", 32'(out_e), 32'hD);
    check("dirA6.f_lit", 32'(out_f), 32'hC);
    in_valid = 1'b0;
    step();
    check_outputs("hold", 1'b0, 1'b0, 1'b0);

    // Back-to-back requests.
    single_op("b2b0", 4'hF, 4'h0);
    check("b2b0.lit", 32'({out_c, out_d, out_e, out_f}), 32'h0FFF);
    single_op("b2b1", 4'h5, 4'h5);
    check("b2b1.lit", 32'({out_c, out_d, out_e, out_f}), 32'h55A0);
    in_valid = 1'b0;
    step();
    check_outputs("b2b.idle", 1'b0, 1'b0, 1'b0);

    // Random single ops with idle gaps.
    for (int i = 0; i < 60; i++) begin
      logic         v;
      logic [W-1:0] a, b;
      v           = 1'($urandom_range(0, 1));
      a           = W'($urandom);
      b           = W'($urandom);
      in_valid    = v;
      in_a        = a;
      in_b        = b;
      sweep_start = 1'b0;
      step();
      if (v) model_load(a, b);
      check_outputs($sformatf("rnd%0d", i), v, 1'b0, 1'b0);
    end

    run_sweep("sw0", 1'b0);
    single_op("post", 4'h7, 4'hC);
    run_sweep("sw1", 1'b1);

    // Reset in the middle of a sweep: no done pulse afterwards.
    in_valid    = 1'b0;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    repeat (20) step();
    rst_n = 1'b0;
    step();
    step();
    model_reset();
    check_outputs("midrst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < N + 4; i++) begin
      step();
      check($sformatf("midrst.nodone%0d", i), 32'({sweep_done, busy, out_valid}), 32'h0);
    end
    single_op("final", 4'h9, 4'h3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
